bram_stack_pingpong: RTL and testbench

- Parametrised BRAM-stack matrix buffer for MLP matrix-vector designs.
- Deep-write loads W-bit words sequentially across M cascaded BRAMs. Wide-read presents all M BRAMs' R-bit rows in parallel to the MLP column.
- Each BRAM is split into two banks (ping-pong), so the matrix for job N+1 loads while job N is read.
- Adds bank-ownership control, streaming valid/ready write, a read-sequencer FSM, and a hold mode that re-reads one bank for multiple vectors.

---
 rtl/bram_stack_pingpong.sv | 198 +++++++++++++++++++
 tb/tb_bram_stack_pingpong.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_stack_pingpong.sv
// bram_stack_pingpong
//   Ping-pong matrix buffer built from M cascaded BRAMs. The writer streams
//   W-bit words deep-first across the stack into one bank. Meanwhile the
//   reader sequences a full pass over the other bank and presents all M
//   R-bit rows in parallel.
//
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_wr_data/valid  write word stream; o_wr_ready accepts it
//   o_wr_bank        bank currently being filled
//   i_rd_start       request one pass over the ready bank
//   i_rd_hold        latched with start; 1 = keep bank after the pass
//   o_rd_busy        pass in progress
//   o_rd_data        M rows in parallel, BRAM b on [b*R +: R]
//   o_rd_valid/last  row valid, final row of a pass
//   o_bank_full      per-bank full flags
//
// RD_LAT must be >= 2: one address register plus the array output register,
// with any extra latency added as output delay stages.
module bram_stack_pingpong #(
    parameter int M      = 6,
    parameter int W      = 64,
    parameter int ROWS   = 256,
    parameter int RD_LAT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [W-1:0]         i_wr_data,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    output logic                 o_wr_bank,
    input  logic                 i_rd_start,
    input  logic                 i_rd_hold,
    output logic                 o_rd_busy,
    output logic [M*2*W-1:0]     o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_rd_last,
    output logic [1:0]           o_bank_full
);
    localparam int R  = 2 * W;
    localparam int RA = $clog2(ROWS);          // row index within a bank
    localparam int WA = RA + 1;                // word index within a bank
    localparam int BW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} rd_state_e;

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [BW-1:0]     wr_blk_q, wr_blk_d;
    logic [WA-1:0]     wr_word_q, wr_word_d;
    rd_state_e         state_q, state_d;
    logic [RA-1:0]     row_q, row_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0] last_pipe_q, last_pipe_d;
    logic [RA:0]       rd_addr_q;

    logic wr_ready, wr_acc, fill_done, rd_issue, rd_last_out, rd_release;
    logic [M*R-1:0] rd_row, rd_data;

    assign wr_ready    = ~full_q[wr_bank_q] & ~i_reset;
    assign wr_acc      = i_wr_valid & wr_ready;
    assign fill_done   = wr_acc & (wr_blk_q == BW'(M - 1)) & (wr_word_q == {WA{1'b1}});
    assign rd_issue    = (state_q == R_RUN);
    assign rd_last_out = last_pipe_q[RD_LAT-1];
    // Hold keeps the bank owned by the reader so the next start re-reads it.
    assign rd_release  = (state_q == R_DRAIN) & rd_last_out & ~hold_q;

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_blk_d  = wr_blk_q;
        wr_word_d = wr_word_q;
        state_d   = state_q;
        row_d     = row_q;
        hold_d    = hold_q;

        // Deep-first: fill all words of one BRAM, then step to the next.
        if (wr_acc) begin
            if (wr_word_q == {WA{1'b1}}) begin
                wr_word_d = '0;
                wr_blk_d  = (wr_blk_q == BW'(M - 1)) ? '0 : wr_blk_q + 1'b1;
            end else begin
                wr_word_d = wr_word_q + 1'b1;
            end
        end

        // Writer and reader always own different banks, so set and clear
        // never hit the same bit.
        if (fill_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        case (state_q)
            R_IDLE: begin
                if (i_rd_start && full_q[rd_bank_q]) begin
                    hold_d  = i_rd_hold;
                    row_d   = '0;
                    state_d = R_RUN;
                end
            end
            R_RUN: begin
                if (row_q == RA'(ROWS - 1)) state_d = R_DRAIN;
                else                        row_d   = row_q + 1'b1;
            end
            R_DRAIN: begin
                if (rd_last_out) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase

        busy_d = (state_d != R_IDLE);

        vld_pipe_d  = {vld_pipe_q[RD_LAT-2:0], rd_issue};
        last_pipe_d = {last_pipe_q[RD_LAT-2:0], rd_issue & (row_q == RA'(ROWS - 1))};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_blk_q    <= '0;
            wr_word_q   <= '0;
            state_q     <= R_IDLE;
            row_q       <= '0;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_blk_q    <= wr_blk_d;
            wr_word_q   <= wr_word_d;
            state_q     <= state_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    // Address register is the first read latency stage; free-running.
    always_ff @(posedge i_clk) rd_addr_q <= {rd_bank_q, row_q};

    // Each BRAM is kept as two W-wide halves so a W-bit write lands in
    // one half while a read returns the full R-bit row.
    for (genvar b = 0; b < M; b++) begin : g_bram
        logic [W-1:0] lo_mem [2*ROWS];
        logic [W-1:0] hi_mem [2*ROWS];
        logic [W-1:0] lo_q, hi_q;
        logic         we;
        logic [RA:0]  waddr;

        assign we    = wr_acc & (wr_blk_q == BW'(b));
        assign waddr = {wr_bank_q, wr_word_q[WA-1:1]};

        always_ff @(posedge i_clk) begin
            if (we && !wr_word_q[0]) lo_mem[waddr] <= i_wr_data;
            if (we &&  wr_word_q[0]) hi_mem[waddr] <= i_wr_data;
            lo_q <= lo_mem[rd_addr_q];
            hi_q <= hi_mem[rd_addr_q];
        end

        assign rd_row[b*R +: R] = {hi_q, lo_q};
    end

    if (RD_LAT > 2) begin : g_dly
        logic [M*R-1:0] dly_q [RD_LAT-2];
        always_ff @(posedge i_clk) begin
            dly_q[0] <= rd_row;
            for (int i = 1; i < RD_LAT - 2; i++) dly_q[i] <= dly_q[i-1];
        end
        assign rd_data = dly_q[RD_LAT-3];
    end else begin : g_nodly
        assign rd_data = rd_row;
    end

    // Outputs forced low for the whole reset cycle, not just after it.
    assign o_wr_ready  = wr_ready;
    assign o_wr_bank   = wr_bank_q & ~i_reset;
    assign o_rd_busy   = busy_q & ~i_reset;
    assign o_rd_valid  = vld_pipe_q[RD_LAT-1] & ~i_reset;
    assign o_rd_last   = rd_last_out & ~i_reset;
    assign o_bank_full = full_q & {2{~i_reset}};
    assign o_rd_data   = rd_data & {(M*R){~i_reset}};
endmodule

// File: tb/tb_bram_stack_pingpong.sv
module tb_bram_stack_pingpong;
    localparam int M = 2, W = 8, ROWS = 4, RD_LAT = 2;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic [W-1:0]      i_wr_data = '0;
    logic              i_wr_valid = 1'b0;
    logic              o_wr_ready, o_wr_bank;
    logic              i_rd_start = 1'b0;
    logic              i_rd_hold = 1'b0;
    logic              o_rd_busy, o_rd_valid, o_rd_last;
    logic [M*2*W-1:0]  o_rd_data;
    logic [1:0]        o_bank_full;

    bram_stack_pingpong #(.M(M), .W(W), .ROWS(ROWS), .RD_LAT(RD_LAT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .o_wr_bank(o_wr_bank),
        .i_rd_start(i_rd_start), .i_rd_hold(i_rd_hold), .o_rd_busy(o_rd_busy),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last),
        .o_bank_full(o_bank_full)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  md [2][16];   // model of each bank's words in write order
    int          wb, widx, rb; // model write bank, word index, read bank
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; any valid
    // row is matched against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_rd_valid) begin
            chk("valid_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rd_data", o_rd_data, e.data);
                chk("rd_last", o_rd_last, e.last);
                chk("rd_cycle", cyc, e.cyc);
            end
        end
    endtask

    task automatic push_rows(input int bank, input int c);
        exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            e.data = {md[bank][9+2*r], md[bank][8+2*r], md[bank][2*r+1], md[bank][2*r]};
            e.last = (r == ROWS - 1);
            e.cyc  = c + RD_LAT + 1 + r;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_wr_valid = 1'b0; i_rd_start = 1'b0; i_rd_hold = 1'b0;
        sb.delete();
        #1;
        chk("rst_valid", o_rd_valid, 1'b0);
        chk("rst_busy", o_rd_busy, 1'b0);
        chk("rst_full", o_bank_full, 2'b00);
        chk("rst_ready", o_wr_ready, 1'b0);
        chk("rst_last", o_rd_last, 1'b0);
        tick();
        tick();
        i_reset = 1'b0;
        wb = 0; widx = 0; rb = 0;
        #1;
        chk("ready_after_rst", o_wr_ready, 1'b1);
    endtask

    task automatic wr_word(input logic [7:0] d);
        i_wr_valid = 1'b1;
        i_wr_data  = d;
        chk("wr_ready", o_wr_ready, 1'b1);
        tick();
        md[wb][widx] = d;
        widx++;
        if (widx == 16) begin widx = 0; wb = 1 - wb; end
        i_wr_valid = 1'b0;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < 16; i++) wr_word(8'(base + i));
        chk("wr_bank_after_fill", o_wr_bank, wb[0]);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 40) begin tick(); g++; end
        chk("drain_in_budget", g < 40, 1'b1);
    endtask

    task automatic pass(input logic hold);
        i_rd_start = 1'b1; i_rd_hold = hold;
        push_rows(rb, cyc);
        tick();
        i_rd_start = 1'b0; i_rd_hold = 1'b0;
        chk("busy_after_start", o_rd_busy, 1'b1);
        wait_drain();
        tick();
        chk("busy_after_pass", o_rd_busy, 1'b0);
        if (!hold) rb = 1 - rb;
    endtask

    initial begin
        // Basic fill and read
        do_reset();
        fill(0);
        chk("full_after_fill0", o_bank_full, 2'b01);
        pass(1'b0);
        chk("full_after_read0", o_bank_full, 2'b00);

        // Stall with both banks full, resume after release
        do_reset();
        fill(100);
        chk("full_one", o_bank_full, 2'b01);
        fill(116);
        chk("full_both", o_bank_full, 2'b11);
        i_wr_valid = 1'b1; i_wr_data = 8'd132;
        #1;
        chk("stall_ready", o_wr_ready, 1'b0);
        tick();
        chk("stall_ready_hold", o_wr_ready, 1'b0);
        i_wr_valid = 1'b0;
        pass(1'b0);
        chk("full_after_release", o_bank_full, 2'b10);
        chk("ready_after_release", o_wr_ready, 1'b1);
        fill(132);
        chk("full_refilled", o_bank_full, 2'b11);
        pass(1'b0);
        chk("full_after_b1", o_bank_full, 2'b01);
        pass(1'b0);
        chk("full_after_b0", o_bank_full, 2'b00);

        // Hold mode re-reads the same bank
        do_reset();
        fill(40);
        pass(1'b1);
        chk("full_after_hold", o_bank_full, 2'b01);
        pass(1'b0);
        chk("full_after_nohold", o_bank_full, 2'b00);

        // Bank-1 fill completion coincides with bank-0 last row
        do_reset();
        fill(60);
        for (int i = 0; i < 16; i++) begin
            if (i == 9) begin
                i_rd_start = 1'b1; i_rd_hold = 1'b0;
                push_rows(rb, cyc);
            end else begin
                i_rd_start = 1'b0;
            end
            wr_word(8'(80 + i));
        end
        i_rd_start = 1'b0;
        rb = 1 - rb;
        chk("sim_full", o_bank_full, 2'b10);
        chk("sim_wr_bank", o_wr_bank, 1'b0);
        chk("sim_sb_empty", sb.size(), 0);
        tick();
        chk("sim_busy", o_rd_busy, 1'b0);
        pass(1'b0);
        chk("sim_full_final", o_bank_full, 2'b00);

        // Reset during the row-1 issue cycle
        do_reset();
        fill(0);
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i_rd_start = (i == 0);
            tick();
            chk("start_ignored_busy", o_rd_busy, 1'b0);
        end
        i_rd_start = 1'b0;
        chk("full_after_midrst", o_bank_full, 2'b00);
        fill(20);
        chk("full_after_refill", o_bank_full, 2'b01);
        pass(1'b0);
        chk("full_end", o_bank_full, 2'b00);
        chk("sb_empty_end", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
